instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage for the single-issue RV32I core. Holds the program counter and drives the word address to the combinational, byte-addressed, little-endian instruction memory. Captures the returned 32-bit instruction into the IF/ID pipeline register for decode. Supports a decode-side stall and a branch/jump redirect from execute that squashes the in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP, 32'h0000_0013, bubble instruction inserted on reset/redirect (addi x0,x0,0).

Ports:
i_Clk  input  1  core clock; all state updates on rising edge.
i_Rst  input  1  synchronous reset, active-high.
o_Addr  output  32  byte address to instruction memory; equals the current PC register, combinational from it.
i_Instruction  input  32  instruction word returned combinationally by memory for o_Addr in the same cycle.
i_Stall  input  1  hold PC and IF/ID register (decode not ready).
i_Redirect  input  1  taken branch/jump; load PC from i_Target and squash.
i_Target  input  32  redirect byte address.
o_PC  output  32  address of the instruction held in IF/ID.
o_Instruction  output  32  IF/ID instruction word.
o_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
o_Misalign  output  1  one-cycle pulse: last redirect target had nonzero bits [1:0].

Behaviour:
- Internal state: PC (32b), IF/ID {o_PC, o_Instruction, o_Valid}, o_Misalign.
- Reset (i_Rst=1 at posedge, overrides everything): PC<=RESET_PC; o_PC<=RESET_PC; o_Instruction<=NOP; o_Valid<=0; o_Misalign<=0. Reset mid-stall or mid-redirect: reset wins, prior state discarded.
- Per posedge, when not in reset, priority is redirect > stall > advance:
  - Redirect (i_Redirect=1, i_Stall ignored): PC<=i_Target with bits[1:0] forced to 00. o_Instruction<=NOP, o_Valid<=0, o_PC<=current PC (don't-care for verification beyond this value). o_Misalign<=|i_Target[1:0].
  - Stall (i_Stall=1, i_Redirect=0): PC, o_PC, o_Instruction, o_Valid all hold. o_Misalign<=0.
  - Advance: o_PC<=PC; o_Instruction<=i_Instruction; o_Valid<=1; PC<=PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0, no flag). o_Misalign<=0.
- Latency: the instruction at address A appears on o_Instruction/o_PC=A exactly one edge after the cycle in which o_Addr=A and advance occurred.
- After reset, first valid instruction (from RESET_PC) appears after the first advance edge.
- After redirect to T: one bubble cycle (o_Valid=0), then o_Addr=T; T's instruction is valid one advance edge later. Net redirect penalty: one bubble in IF/ID plus the squashed fetch.
- Back-to-back redirects: each takes effect; the latest target wins; o_Valid stays 0.
- i_Stall held for N cycles: outputs frozen for N edges, no instruction dropped or duplicated.
- o_Addr is always word-aligned (bits[1:0]=00 by construction).
- No combinational path from i_Stall/i_Redirect/i_Target to any output.

Test Plan:
- Reset with RESET_PC=0, memory words 0x00500093, 0x00A00113, … at 0,4,… -> after reset o_Valid=0, o_Instruction=0x00000013, o_Addr=0; edge1: o_PC=0, o_Instruction=0x00500093, o_Valid=1, o_Addr=4; edge2: o_PC=4, o_Instruction=0x00A00113.
- Stall asserted 3 cycles while IF/ID holds PC=8 -> o_PC=8, o_Instruction unchanged, o_Addr=12 for all 3 cycles; after release, next edge gives o_PC=12, no skip or repeat.
- Redirect to 0x40 while PC=0x10 -> next edge o_Valid=0, o_Instruction=NOP, o_Addr=0x40, o_Misalign=0; following edge o_PC=0x40, o_Valid=1.
- Redirect to 0x42 with i_Stall=1 -> redirect wins: o_Addr=0x40, o_Misalign=1 for one cycle then 0, o_Valid=0.
- Force PC to 0xFFFFFFFC via redirect, then advance -> o_PC=0xFFFFFFFC, o_Addr=0x00000000 (wrap).
- i_Rst asserted together with i_Redirect (target 0x80) mid-stream -> PC=RESET_PC, o_Valid=0, o_Instruction=NOP, o_Misalign=0; redirect ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: program counter, instruction memory address and the
// IF/ID pipeline register. Redirects from execute squash the fetch that is
// in flight; decode stalls freeze the PC and IF/ID contents.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic [31:0] o_Addr,
  input  logic [31:0] i_Instruction,
  input  logic        i_Stall,
  input  logic        i_Redirect,
  input  logic [31:0] i_Target,
  output logic [31:0] o_PC,
  output logic [31:0] o_Instruction,
  output logic        o_Valid,
  output logic        o_Misalign
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic        misalign_q, misalign_d;

  // Next-state selection: redirect beats stall, stall beats advance.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_vld_d   = ifid_vld_q;
    misalign_d   = 1'b0;
    if (i_Redirect) begin
      // Low address bits are dropped so the PC stays word aligned; the
      // misalignment is reported rather than trapped here.
      pc_d         = {i_Target[31:2], 2'b00};
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP;
      ifid_vld_d   = 1'b0;
      misalign_d   = |i_Target[1:0];
    end else if (!i_Stall) begin
      // PC increment wraps naturally modulo 2^32.
      pc_d         = pc_q + 32'd4;
      ifid_pc_d    = pc_q;
      ifid_instr_d = i_Instruction;
      ifid_vld_d   = 1'b1;
    end
  end

  // State registers with synchronous reset that overrides stall/redirect.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= RESET_PC;
      ifid_instr_q <= NOP;
      ifid_vld_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_vld_q   <= ifid_vld_d;
      misalign_q   <= misalign_d;
    end
  end

  // All outputs come straight from registers.
  assign o_Addr        = pc_q;
  assign o_PC          = ifid_pc_q;
  assign o_Instruction = ifid_instr_q;
  assign o_Valid       = ifid_vld_q;
  assign o_Misalign    = misalign_q;

endmodule
